// File: rtl/dose_sched_pkg.sv
// Shared definitions for the dose alarm scheduler: schedule ROM word layout,
// scan FSM states and the pending-dose queue entry.
`timescale 1ns/1ps
package dose_sched_pkg;

  localparam int unsigned ROM_W    = 28;
  localparam int unsigned PILL_MSB = 27;
  localparam int unsigned PILL_LSB = 24;
  localparam int unsigned HOUR_MSB = 23;
  localparam int unsigned HOUR_LSB = 16;
  localparam int unsigned MIN_MSB  = 15;
  localparam int unsigned MIN_LSB  = 8;
  localparam int unsigned DOSE_MSB = 3;
  localparam int unsigned DOSE_LSB = 0;

  localparam int unsigned MISSED_MAX = 255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    WAIT = 2'd2,
    CMP  = 2'd3
  } scanState_t;

  typedef struct packed {
    logic [3:0] pill;
    logic [3:0] dose;
  } pendingEntry_t;

endpackage

// File: rtl/pending_dose_fifo.sv
// Pending-dose queue: synchronous FIFO, head shown combinationally from
// registered storage (zero when empty). A push into a full queue is accepted
// only when a pop happens in the same cycle.
`timescale 1ns/1ps
module pending_dose_fifo
  import dose_sched_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     resetN,
  input  logic                     push,
  input  pendingEntry_t            pushData,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output pendingEntry_t            head
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  pendingEntry_t  mem [DEPTH];
  logic [AW-1:0]  wrPtr;
  logic [AW-1:0]  rdPtr;
  logic           pushOk_c;
  logic           popOk_c;

  assign popOk_c  = pop && !empty;
  assign pushOk_c = push && (!full || popOk_c);
  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign head     = empty ? '0 : mem[rdPtr];

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (pushOk_c) wrPtr <= wrPtr + AW'(1);
      if (popOk_c)  rdPtr <= rdPtr + AW'(1);
      count <= count + CW'(pushOk_c) - CW'(popOk_c);
    end
  end

  // Entry storage; contents are don't-care while unoccupied
  always_ff @(posedge clk) begin
    if (pushOk_c) mem[wrPtr] <= pushData;
  end

endmodule

// File: rtl/dose_alarm_scheduler.sv
// Dose alarm scheduler: scans the schedule ROM once per minute, queues every
// dose due now and drives one alarm for the oldest pending dose with
// acknowledge, snooze and missed-dose timeout handling.
`timescale 1ns/1ps
module dose_alarm_scheduler
  import dose_sched_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES = 16,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned TIMEOUT_MIN = 15,
  parameter int unsigned SNOOZE_MIN  = 5
) (
  input  logic                          clk,
  input  logic                          resetN,
  input  logic                          enable,
  input  logic [23:0]                   timeBcd,
  input  logic                          ackPulse,
  input  logic                          snoozePulse,
  output logic [7:0]                    romAddress,
  input  logic [ROM_W-1:0]              romData,
  output logic                          alarmActive,
  output logic [3:0]                    alarmPill,
  output logic [3:0]                    alarmDose,
  output logic [$clog2(FIFO_DEPTH):0]   pendingCount,
  output logic [7:0]                    missedCount,
  output logic                          missedPulse,
  output logic                          scanBusy
);

  localparam int unsigned IDX_W = 8;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned AGE_W = $clog2(TIMEOUT_MIN + 1);
  localparam int unsigned SNZ_W = $clog2(SNOOZE_MIN + 1);

  scanState_t        state;
  logic [IDX_W-1:0]  index;
  logic              scanReq;
  logic [7:0]        prevMinute;
  logic [AGE_W-1:0]  age;
  logic [SNZ_W-1:0]  snoozeLeft;

  logic              tick_c;
  logic              cmpPush_c;
  pendingEntry_t     cmpEntry_c;
  logic              fifoFull;
  logic              fifoEmpty;
  logic [CNT_W-1:0]  fifoCount;
  pendingEntry_t     fifoHead;
  logic              ackPop_c;
  logic              timeout_c;
  logic              popDo_c;
  logic              pushAcc_c;
  logic              drop_c;
  logic              miss_c;
  logic              snoozeSet_c;
  logic [CNT_W-1:0]  pendingNext_c;
  logic [AGE_W-1:0]  ageNext_c;
  logic [SNZ_W-1:0]  snoozeNext_c;
  logic              unusedBits;

  assign unusedBits = ^{romData[7:4], timeBcd[7:0]};

  assign tick_c = enable && (timeBcd[15:8] != prevMinute);

  assign cmpEntry_c.pill = romData[PILL_MSB:PILL_LSB];
  assign cmpEntry_c.dose = romData[DOSE_MSB:DOSE_LSB];
  assign cmpPush_c = (state == CMP)
                  && (romData[PILL_MSB:PILL_LSB] != 4'h0)
                  && (romData[HOUR_MSB:HOUR_LSB] == timeBcd[23:16])
                  && (romData[MIN_MSB:MIN_LSB]   == timeBcd[15:8]);

  // Ack beats timeout beats snooze; ack plus timeout counts as taken
  assign ackPop_c    = ackPulse && !fifoEmpty;
  assign timeout_c   = tick_c && !fifoEmpty && (age == AGE_W'(TIMEOUT_MIN - 1));
  assign popDo_c     = ackPop_c || timeout_c;
  assign pushAcc_c   = cmpPush_c && (!fifoFull || popDo_c);
  assign drop_c      = cmpPush_c && fifoFull && !popDo_c;
  assign miss_c      = drop_c || (timeout_c && !ackPop_c);
  assign snoozeSet_c = snoozePulse && alarmActive && !popDo_c;

  assign pendingNext_c = fifoCount + CNT_W'(pushAcc_c) - CNT_W'(popDo_c);

  // Next values of head age and snooze countdown
  always_comb begin
    ageNext_c    = age;
    snoozeNext_c = snoozeLeft;
    if (popDo_c)                  ageNext_c = '0;
    else if (tick_c && !fifoEmpty) ageNext_c = age + AGE_W'(1);
    if (ackPop_c)                              snoozeNext_c = '0;
    else if (snoozeSet_c)                      snoozeNext_c = SNZ_W'(SNOOZE_MIN);
    else if (tick_c && (snoozeLeft != '0))     snoozeNext_c = snoozeLeft - SNZ_W'(1);
  end

  pending_dose_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) uFifo (
    .clk      (clk),
    .resetN   (resetN),
    .push     (cmpPush_c),
    .pushData (cmpEntry_c),
    .pop      (popDo_c),
    .full     (fifoFull),
    .empty    (fifoEmpty),
    .count    (fifoCount),
    .head     (fifoHead)
  );

  assign pendingCount = fifoCount;
  assign alarmPill    = fifoHead.pill;
  assign alarmDose    = fifoHead.dose;

  // ROM scan sequencer with one-deep latch for ticks arriving mid-scan
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state      <= IDLE;
      index      <= '0;
      scanReq    <= 1'b0;
      romAddress <= '0;
      scanBusy   <= 1'b0;
      prevMinute <= 8'h00;
    end else begin
      prevMinute <= timeBcd[15:8];
      if (state != IDLE && tick_c) scanReq <= 1'b1;
      case (state)
        IDLE: begin
          if (tick_c || (scanReq && enable)) begin
            state    <= ADDR;
            index    <= '0;
            scanReq  <= 1'b0;
            scanBusy <= 1'b1;
          end
        end
        ADDR: begin
          romAddress <= index;
          state      <= WAIT;
        end
        WAIT: begin
          state <= CMP;
        end
        CMP: begin
          if (index < IDX_W'(NUM_ENTRIES - 1)) begin
            index <= index + IDX_W'(1);
            state <= ADDR;
          end else begin
            state    <= IDLE;
            scanBusy <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          scanBusy <= 1'b0;
        end
      endcase
    end
  end

  // Alarm, age, snooze and missed-dose bookkeeping
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      age         <= '0;
      snoozeLeft  <= '0;
      alarmActive <= 1'b0;
      missedCount <= '0;
      missedPulse <= 1'b0;
    end else begin
      age         <= ageNext_c;
      snoozeLeft  <= snoozeNext_c;
      alarmActive <= (pendingNext_c != '0) && (snoozeNext_c == '0);
      missedPulse <= miss_c;
      if (miss_c && (missedCount != 8'(MISSED_MAX)))
        missedCount <= missedCount + 8'd1;
    end
  end

endmodule

// File: tb/tb_dose_alarm_scheduler.sv
// Directed bench for dose_alarm_scheduler with a one-cycle-latency ROM model.
`timescale 1ns/1ps
module tb_dose_alarm_scheduler;
  import dose_sched_pkg::*;

  logic        clk = 1'b0;
  logic        resetN;
  logic        enable;
  logic [23:0] timeBcd;
  logic        ackPulse;
  logic        snoozePulse;
  logic [7:0]  romAddress;
  logic [27:0] romData;
  logic        alarmActive;
  logic [3:0]  alarmPill;
  logic [3:0]  alarmDose;
  logic [2:0]  pendingCount;
  logic [7:0]  missedCount;
  logic        missedPulse;
  logic        scanBusy;

  logic [27:0] rom [0:15];
  int          passed = 0;
  int          total  = 0;
  int          pulseCnt = 0;

  always #5 clk = ~clk;

  dose_alarm_scheduler dut (
    .clk          (clk),
    .resetN       (resetN),
    .enable       (enable),
    .timeBcd      (timeBcd),
    .ackPulse     (ackPulse),
    .snoozePulse  (snoozePulse),
    .romAddress   (romAddress),
    .romData      (romData),
    .alarmActive  (alarmActive),
    .alarmPill    (alarmPill),
    .alarmDose    (alarmDose),
    .pendingCount (pendingCount),
    .missedCount  (missedCount),
    .missedPulse  (missedPulse),
    .scanBusy     (scanBusy)
  );

  // Synchronous ROM: data follows the address by one clock
  always @(posedge clk) romData <= rom[romAddress[3:0]];

  // Count missed-dose pulses seen on the output
  always @(negedge clk) if (missedPulse === 1'b1) pulseCnt <= pulseCnt + 1;

  function automatic logic [7:0] bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic setMinute(input int hh, input int mm);
    timeBcd = {bcd(hh), bcd(mm), 8'h00};
    cyc(60);
  endtask

  task automatic ackOnce();
    ackPulse = 1'b1;
    cyc(1);
    ackPulse = 1'b0;
  endtask

  initial begin
    int n;
    int busy;
    int base;
    resetN = 1'b0; enable = 1'b0; ackPulse = 1'b0; snoozePulse = 1'b0;
    timeBcd = 24'h082959;
    for (int i = 0; i < 16; i++) rom[i] = '0;
    rom[0] = {4'h3, 8'h08, 8'h30, 4'h0, 4'h2};
    rom[1] = {4'h7, 8'h09, 8'h00, 4'h0, 4'h1};
    rom[2] = {4'h9, 8'h10, 8'h00, 4'h0, 4'h3};
    cyc(3);
    check("rst_alarm",   32'(alarmActive), 0);
    check("rst_pending", 32'(pendingCount), 0);
    check("rst_missed",  32'(missedCount), 0);
    check("rst_busy",    32'(scanBusy), 0);
    check("rst_addr",    32'(romAddress), 0);

    // Initial tick at 08:29 scans without a match
    resetN = 1'b1; enable = 1'b1;
    cyc(60);
    check("no_match_pending", 32'(pendingCount), 0);

    // Test 1: 08:30 match, 48-cycle scan
    timeBcd = 24'h083000;
    n = 0;
    while (scanBusy !== 1'b1 && n < 10) begin cyc(1); n++; end
    busy = 0;
    while (scanBusy === 1'b1 && busy < 200) begin cyc(1); busy++; end
    check("scan_len",   32'(busy), 48);
    check("t1_alarm",   32'(alarmActive), 1);
    check("t1_pill",    32'(alarmPill), 3);
    check("t1_dose",    32'(alarmDose), 2);
    check("t1_pending", 32'(pendingCount), 1);

    // Test 2: acknowledge
    ackOnce();
    check("t2_alarm",   32'(alarmActive), 0);
    check("t2_pending", 32'(pendingCount), 0);
    check("t2_missed",  32'(missedCount), 0);

    // Test 3: timeout after 15 ticks
    setMinute(9, 0);
    check("t3_alarm", 32'(alarmActive), 1);
    check("t3_pill",  32'(alarmPill), 7);
    base = pulseCnt;
    for (int m = 1; m <= 14; m++) setMinute(9, m);
    check("t3_alarm14",   32'(alarmActive), 1);
    check("t3_pending14", 32'(pendingCount), 1);
    setMinute(9, 15);
    check("t3_pulses",  32'(pulseCnt - base), 1);
    check("t3_missed",  32'(missedCount), 1);
    check("t3_alarm15", 32'(alarmActive), 0);
    check("t3_pending", 32'(pendingCount), 0);

    // Test 4: snooze for 5 ticks, timeout still at tick 15
    setMinute(10, 0);
    check("t4_alarm", 32'(alarmActive), 1);
    check("t4_pill",  32'(alarmPill), 9);
    snoozePulse = 1'b1;
    cyc(1);
    snoozePulse = 1'b0;
    check("t4_snoozed", 32'(alarmActive), 0);
    for (int m = 1; m <= 4; m++) setMinute(10, m);
    check("t4_snoozed4", 32'(alarmActive), 0);
    setMinute(10, 5);
    check("t4_resound", 32'(alarmActive), 1);
    for (int m = 6; m <= 14; m++) setMinute(10, m);
    check("t4_pending14", 32'(pendingCount), 1);
    check("t4_missed14",  32'(missedCount), 1);
    setMinute(10, 15);
    check("t4_missed",  32'(missedCount), 2);
    check("t4_pending", 32'(pendingCount), 0);
    check("t4_alarm",   32'(alarmActive), 0);

    // Disabled counter starts no scan
    enable = 1'b0;
    timeBcd = 24'h101600;
    cyc(5);
    check("dis_busy", 32'(scanBusy), 0);
    enable = 1'b1;

    // Test 6: reset in the middle of the 12:00 scan
    for (int i = 0; i < 16; i++) rom[i] = '0;
    for (int i = 0; i < 5; i++) rom[i] = {4'(i + 1), 8'h12, 8'h00, 4'h0, 4'(i + 1)};
    setMinute(11, 59);
    timeBcd = 24'h120000;
    cyc(20);
    check("t6_pre_pending", 32'(pendingCount), 4);
    resetN = 1'b0;
    #2;
    check("t6_alarm",   32'(alarmActive), 0);
    check("t6_pending", 32'(pendingCount), 0);
    check("t6_missed",  32'(missedCount), 0);
    check("t6_busy",    32'(scanBusy), 0);
    check("t6_pill",    32'(alarmPill), 0);
    check("t6_addr",    32'(romAddress), 0);
    cyc(2);
    resetN = 1'b1;
    cyc(80);
    check("t6_hold_alarm",   32'(alarmActive), 0);
    check("t6_hold_pending", 32'(pendingCount), 0);

    // Test 5: five matches into a four-deep queue
    setMinute(11, 59);
    setMinute(12, 0);
    check("t5_pending", 32'(pendingCount), 4);
    check("t5_missed",  32'(missedCount), 1);
    check("t5_alarm",   32'(alarmActive), 1);
    for (int k = 0; k < 4; k++) begin
      check("t5_head_pill", 32'(alarmPill), 32'(k + 1));
      check("t5_head_dose", 32'(alarmDose), 32'(k + 1));
      ackOnce();
      cyc(1);
    end
    check("t5_empty", 32'(pendingCount), 0);
    check("t5_quiet", 32'(alarmActive), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/dose_alarm_scheduler.md
Name: dose_alarm_scheduler

Overview:
- Sequences the dose-schedule ROM once per minute and compares each entry against the running BCD time-of-day.
- Queues every matching dose and drives a single alarm for the oldest pending dose.
- Handles acknowledge, snooze and missed-dose timeout for that alarm.
- Sits between the shaped push-buttons, the time-of-day counter and the schedule ROM; its alarm outputs feed the display and LCD path.

Parameters:
NUM_ENTRIES, 16, ROM entries scanned per minute (addresses 0..NUM_ENTRIES-1, max 256)
FIFO_DEPTH, 4, pending-dose queue depth (power of two)
TIMEOUT_MIN, 15, minute ticks an un-acknowledged dose may stay pending before it counts as missed
SNOOZE_MIN, 5, minute ticks the alarm stays silenced after snooze

Ports:
clk  in  1  system clock
resetN  in  1  asynchronous active-low reset
enable  in  1  time-of-day counter running; gates minute ticks
timeBcd  in  24  current time {HH,MM,SS}, BCD
ackPulse  in  1  one-cycle shaped acknowledge ("pill taken")
snoozePulse  in  1  one-cycle shaped snooze request
romAddress  out  8  schedule ROM address
romData  in  28  ROM word; valid one cycle after romAddress changes: [27:24] pill id (0 = empty slot), [23:16] hour BCD, [15:8] minute BCD, [7:4] reserved, [3:0] dose count
alarmActive  out  1  alarm sounding for queue head
alarmPill  out  4  pill id of queue head (0 when queue empty)
alarmDose  out  4  dose count of queue head (0 when queue empty)
pendingCount  out  3  doses queued, 0..FIFO_DEPTH
missedCount  out  8  missed doses, saturates at 255
missedPulse  out  1  one-cycle pulse per missed dose
scanBusy  out  1  high while scanning ROM

Behaviour:
- Reset (async, resetN=0): all outputs 0, FIFO emptied, FSM=IDLE, prevMinute=8'h00, snooze and age counters 0, pending scan request cleared.
- prevMinute register captures timeBcd[15:8] every cycle.
- Minute tick: timeBcd[15:8] != prevMinute and enable=1. After reset this fires on the first enabled cycle if the minute is non-zero.
- Scan FSM states: IDLE, ADDR, WAIT, CMP.
  - IDLE -> ADDR on a tick or a latched request. Entering ADDR sets index=0.
  - ADDR drives romAddress=index, then goes to WAIT.
  - WAIT holds for the ROM latency, then goes to CMP.
  - CMP compares romData with the time. A match is pillId!=0, hour==timeBcd[23:16] and minute==timeBcd[15:8]; a match pushes {pill,dose}.
  - CMP -> ADDR with index+1 while index<NUM_ENTRIES-1, otherwise -> IDLE.
  - scanBusy=1 in ADDR, WAIT and CMP. A scan takes 3*NUM_ENTRIES cycles.
- Tick during a scan: latched as one request and served on return to IDLE. Further ticks while the request is set are absorbed.
- Push when the FIFO is full: the entry is dropped, missedCount increments and missedPulse=1.
- enable=0: no new scan starts, an in-progress scan completes, age and snooze counters freeze.
- alarmActive = (pendingCount!=0) && (snoozeLeft==0), registered. alarmPill and alarmDose show the FIFO head.
- Age counter tracks the head dose.
  - Increments on each tick while pendingCount!=0, including during snooze.
  - Clears on every pop.
  - Reaching TIMEOUT_MIN pops the head, missedCount+1 and missedPulse=1.
- ackPulse with pendingCount!=0 (alarm active or snoozed): pops the head and clears snoozeLeft. With an empty queue it is ignored.
- snoozePulse with alarmActive=1: snoozeLeft=SNOOZE_MIN, decremented on each tick. Otherwise ignored.
- Priority within one cycle: ack > timeout > snooze. Ack and timeout together count as taken, not missed.
- Push and pop in the same cycle are both performed; pendingCount is unchanged.
- All outputs update one cycle after the causing event.
- Minute/hour comparisons are raw 8-bit BCD equality; no BCD arithmetic.

Decomposition:
- Package dose_sched_pkg holds:
  - ROM field offsets and widths (PILL_MSB/LSB, HOUR_*, MIN_*, DOSE_*).
  - Scan state enum {IDLE, ADDR, WAIT, CMP}.
  - Pending entry typedef {pill[3:0], dose[3:0]}.
  - MISSED_MAX=255.
- One sub-module: pending_dose_fifo. It is a synchronous FIFO of pending entries with push, pop, full, empty, count and head outputs, and it handles simultaneous push/pop.

Test Plan:
- ROM[0]={4'h3,8'h08,8'h30,8'h02}, time 08:29:59 -> 08:30:00 -> scanBusy for 48 cycles, then alarmActive=1, alarmPill=3, alarmDose=2, pendingCount=1.
- Continue test 1 with ackPulse -> next cycle alarmActive=0, pendingCount=0, missedCount=0.
- Continue test 1 with no ack and 15 minute ticks -> one missedPulse, missedCount=1, alarmActive=0, pendingCount=0.
- Continue test 1 with snoozePulse -> alarmActive=0 for 5 ticks, then 1 again; timeout still fires at tick 15 counted from the push.
- ROM[0..4] all match 12:00, pill ids 1..5 -> pendingCount=4, missedCount=1; successive acks present pills 1, 2, 3, 4.
- resetN low mid-scan -> all outputs 0 immediately; after release and with the same minute held, no alarm appears until the minute changes.
